// File: rtl/bus_arb_pkg.sv
// Shared types for the round-robin bus_if arbiter: the byte-wide beat type
// and the two-state arbitration FSM encoding.
package bus_arb_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_if_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_if_arbiter.sv
// Round-robin arbiter sharing one byte-wide bus_if channel among NUM_REQ
// requesters with a per-grant burst limit. Optional BUS_ARB_LOCK_EN adds lock_i.
module bus_if_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 16,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  byte_t [NUM_REQ-1:0]   req_data_i,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock_i,
`endif
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  bus_valid_o,
  output byte_t                 bus_data_o,
  input  logic                  bus_ready_i,
  output logic [IW-1:0]         bus_owner_o
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic               beat_acc;
  logic               locked;
  logic               limit_hit;
  logic [CW-1:0]      cnt_inc;
  logic [IW-1:0]      next_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Output mux is driven purely by the registered owner.
  always_comb begin
    bus_valid_o = 1'b0;
    bus_data_o  = 8'h00;
    if (state_q == BUSY) begin
      bus_valid_o = req_i[owner_q];
      bus_data_o  = req_data_i[owner_q];
    end
  end

`ifdef BUS_ARB_LOCK_EN
  assign locked = lock_i[owner_q];
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    beat_acc  = bus_valid_o && bus_ready_i;
    cnt_inc   = (beat_cnt_q == CW'(MAX_BEATS)) ? beat_cnt_q : beat_cnt_q + CW'(1);
    limit_hit = beat_acc && (cnt_inc == CW'(MAX_BEATS)) && !locked;
    next_ptr  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d      = pick_gnt;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // A dropped request or a full burst hands the bus on after one idle cycle.
        if (!req_i[owner_q] || limit_hit) begin
          gnt_d      = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = next_ptr;
          state_d    = IDLE;
        end else if (beat_acc) begin
          beat_cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign bus_owner_o = owner_q;

`ifndef SYNTHESIS
  // A stalled owner must keep its request up and its byte steady.
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY && bus_valid_o && !bus_ready_i)
      |=> (req_i[owner_q] && bus_data_o == $past(bus_data_o)));
`endif

endmodule
